uart_rx: RTL and testbench

//  UART receiver, 8N1 by default: LSB first, one start bit, one stop bit, no parity.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync2.sv | 29 ++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and the default
// oversampling ratio. Imported by uart_rx now and by uart_tx later.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Ports:
//   clk  in   1      sampling clock
//   rst  in   1      async active-high reset; both flops load RST_VAL
//   d    in   WIDTH  asynchronous input
//   q    out  WIDTH  synchronised output (two clk latency)
module uart_sync2 #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (default 8N1, LSB first). The rx line is synchronised, then
// sampled at mid-bit using a shared oversampling tick (OVERSAMPLE ticks/bit).
// Ports:
//   clk        in   1          system clock
//   rst        in   1          async active-high reset
//   tick       in   1          oversample strobe, one clk wide
//   rx         in   1          serial line, idles high
//   rx_data    out  DATA_BITS  last good byte, held until the next good frame
//   rx_valid   out  1          one-clk pulse when rx_data updates
//   frame_err  out  1          one-clk pulse when the stop bit samples low
//   busy       out  1          high whenever the FSM is not in IDLE
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_t          state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] sh;

    // Reset value 1 keeps the synchronised line idle so reset never looks like a start bit.
    uart_sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            sh        <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Strobes last exactly one clk, independent of tick spacing.
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                tick_cnt <= tick_cnt + 1'b1;
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == HALF_LAST) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                // Start bit did not hold to mid-bit: glitch.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            sh       <= {rx_s, sh[DATA_BITS-1:1]};
                            if (bit_cnt == BIT_LAST) state <= STOP;
                            else                     bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            if (rx_s) begin
                                // Back to IDLE at mid-stop so a following start edge is caught.
                                rx_data  <= sh;
                                rx_valid <= 1'b1;
                                state    <= IDLE;
                                busy     <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HI;
                            end
                        end
                    end
                    WAIT_HI: begin
                        // Swallow the rest of a break so it yields a single error.
                        if (rx_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 8N1, OVERSAMPLE=16, tick every 4 clk (64 clk/bit).
module tb_uart_rx;

    localparam int BIT = 640;   // one bit period in time units (64 clk of 10)

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int failures = 0;

    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_wide = 0;
    int         n_both = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] dq[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid++;
            dq.push_back(rx_data);
            if (prev_valid) n_wide++;
            if (frame_err)  n_both++;
        end
        if (frame_err) n_ferr++;
        prev_valid = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bt);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #(bt);
        end
        rx = stop;
        #(bt);
        rx = 1'b1;
    endtask

    int bv, bf;

    initial begin
        // Reset state
        #23;
        chk("rst_data",  32'(rx_data),   32'h0);
        chk("rst_valid", 32'(rx_valid),  32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        #40 rst = 1'b0;
        #(BIT);

        // 1. Good frame 0xA5
        bv = n_valid; bf = n_ferr;
        send_frame(8'hA5, 1'b1, BIT);
        #(BIT);
        chk("t1_nvalid", 32'(n_valid - bv), 32'd1);
        chk("t1_qdata",  32'(dq[bv]),       32'hA5);
        chk("t1_data",   32'(rx_data),      32'hA5);
        chk("t1_nferr",  32'(n_ferr - bf),  32'd0);
        chk("t1_busy",   32'(busy),         32'h0);

        // 2. Glitch: low for 3 ticks
        bv = n_valid; bf = n_ferr;
        rx = 1'b0;
        #120;
        chk("t2_busy_hi", 32'(busy), 32'h1);
        rx = 1'b1;
        #(2*BIT);
        chk("t2_nvalid",  32'(n_valid - bv), 32'd0);
        chk("t2_nferr",   32'(n_ferr - bf),  32'd0);
        chk("t2_busy_lo", 32'(busy),         32'h0);

        // 3. Framing error then long break
        bv = n_valid; bf = n_ferr;
        send_frame(8'h3C, 1'b0, BIT);
        rx = 1'b0;
        #(30*BIT);
        chk("t3_nferr",   32'(n_ferr - bf),  32'd1);
        chk("t3_nvalid",  32'(n_valid - bv), 32'd0);
        chk("t3_data",    32'(rx_data),      32'hA5);
        chk("t3_busy_hi", 32'(busy),         32'h1);
        rx = 1'b1;
        #(BIT);
        chk("t3_busy_lo", 32'(busy),         32'h0);
        chk("t3_nferr2",  32'(n_ferr - bf),  32'd1);

        // 4. Back-to-back 0x00, 0xFF
        bv = n_valid; bf = n_ferr;
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        #(BIT);
        chk("t4_nvalid", 32'(n_valid - bv), 32'd2);
        chk("t4_q0",     32'(dq[bv]),       32'h00);
        chk("t4_q1",     32'(dq[bv+1]),     32'hFF);
        chk("t4_nferr",  32'(n_ferr - bf),  32'd0);

        // 5. Reset in the middle of data bit 4
        bv = n_valid; bf = n_ferr;
        rx = 1'b0;
        #(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            #(BIT);
        end
        rx = 1'b1;
        #(BIT/2);
        chk("t5_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        #2;
        chk("t5_rst_data",  32'(rx_data),   32'h0);
        chk("t5_rst_busy",  32'(busy),      32'h0);
        chk("t5_rst_valid", 32'(rx_valid),  32'h0);
        chk("t5_rst_ferr",  32'(frame_err), 32'h0);
        #50 rst = 1'b0;
        #(2*BIT);
        send_frame(8'h5A, 1'b1, BIT);
        #(BIT);
        chk("t5_nvalid", 32'(n_valid - bv), 32'd1);
        chk("t5_data",   32'(rx_data),      32'h5A);
        chk("t5_nferr",  32'(n_ferr - bf),  32'd0);

        // 6. Baud error +/-2% (653 and 627 time units per bit)
        bv = n_valid; bf = n_ferr;
        send_frame(8'h81, 1'b1, 627);
        #(BIT);
        chk("t6_fast_nvalid", 32'(n_valid - bv), 32'd1);
        chk("t6_fast_data",   32'(rx_data),      32'h81);
        chk("t6_fast_nferr",  32'(n_ferr - bf),  32'd0);
        rst = 1'b1;
        #20 rst = 1'b0;
        #(BIT);
        bv = n_valid; bf = n_ferr;
        send_frame(8'h81, 1'b1, 653);
        #(BIT);
        chk("t6_slow_nvalid", 32'(n_valid - bv), 32'd1);
        chk("t6_slow_data",   32'(rx_data),      32'h81);
        chk("t6_slow_nferr",  32'(n_ferr - bf),  32'd0);

        // Pulse shape over the whole run
        chk("valid_width", 32'(n_wide), 32'd0);
        chk("valid_ferr_overlap", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
